// File: rtl/decoder_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// decoder_scan_ctrl_if
// Groups the scan control/configuration inputs and the decoder drive outputs
// of decoder_scan_ctrl into one bundle.
//   start, abort, hold      : scan control requests
//   first_addr, last_addr   : inclusive scan range (wraps 1023 -> 0)
//   dwell                   : extra hold cycles per decoder line
//   dec_in, dec_en          : select value and enable to the 10-to-1024 decoder
//   busy, done, aborted     : scan status (done/aborted are one-cycle pulses)
// Modports: master drives control/config, slave is the scan controller.
// -----------------------------------------------------------------------------
interface decoder_scan_ctrl_if #(
    parameter int DWELL_W = 4
);
    logic               start;
    logic               abort;
    logic               hold;
    logic [9:0]         first_addr;
    logic [9:0]         last_addr;
    logic [DWELL_W-1:0] dwell;
    logic [9:0]         dec_in;
    logic               dec_en;
    logic               busy;
    logic               done;
    logic               aborted;

    modport master (
        output start, abort, hold, first_addr, last_addr, dwell,
        input  dec_in, dec_en, busy, done, aborted
    );

    modport slave (
        input  start, abort, hold, first_addr, last_addr, dwell,
        output dec_in, dec_en, busy, done, aborted
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// -----------------------------------------------------------------------------
// decoder_scan_ctrl
// Steps a 10-to-1024 line decoder through an address range, holding each line
// for dwell+1 cycles. The range wraps from 1023 to 0 when first > last.
// Ports:
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : decoder_scan_ctrl_if.slave (control, config, decoder drive, status)
// All outputs come straight from registers; the combinational process computes
// the next value of every register, the sequential process only stores it.
// -----------------------------------------------------------------------------
module decoder_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    decoder_scan_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2,
        ST_ABRT = 2'd3
    } state_t;

    state_t             state_r,   state_s;
    logic [9:0]         dec_in_r,  dec_in_s;
    logic               dec_en_r,  dec_en_s;
    logic               busy_r,    busy_s;
    logic               done_r,    done_s;
    logic               aborted_r, aborted_s;
    logic [DWELL_W-1:0] cnt_r,     cnt_s;
    logic [9:0]         last_r,    last_s;
    logic [DWELL_W-1:0] dwell_r,   dwell_s;

    // Next-state and next-output computation for the scan sequencer.
    always_comb begin
        state_s   = state_r;
        dec_in_s  = dec_in_r;
        dec_en_s  = dec_en_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        aborted_s = 1'b0;
        cnt_s     = cnt_r;
        last_s    = last_r;
        dwell_s   = dwell_r;

        case (state_r)
            ST_IDLE: begin
                dec_en_s = 1'b0;
                busy_s   = 1'b0;
                // abort takes priority over a simultaneous start
                if (bus.start && !bus.abort) begin
                    state_s  = ST_SCAN;
                    last_s   = bus.last_addr;
                    dwell_s  = bus.dwell;
                    cnt_s    = bus.dwell;
                    dec_in_s = bus.first_addr;
                    dec_en_s = 1'b1;
                    busy_s   = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end

            ST_SCAN: begin
                if (bus.abort) begin
                    state_s   = ST_ABRT;
                    dec_en_s  = 1'b0;
                    busy_s    = 1'b0;
                    aborted_s = 1'b1;
                end else if (bus.hold) begin
                    state_s = ST_SCAN;
                end else if (cnt_r != {DWELL_W{1'b0}}) begin
                    cnt_s = cnt_r - DWELL_W'(1);
                end else if (dec_in_r != last_r) begin
                    // 10-bit add wraps 1023 -> 0 for free
                    dec_in_s = dec_in_r + 10'd1;
                    cnt_s    = dwell_r;
                end else begin
                    state_s  = ST_DONE;
                    dec_en_s = 1'b0;
                    busy_s   = 1'b0;
                    done_s   = 1'b1;
                end
            end

            ST_DONE: begin
                state_s  = ST_IDLE;
                dec_en_s = 1'b0;
                busy_s   = 1'b0;
            end

            ST_ABRT: begin
                state_s  = ST_IDLE;
                dec_en_s = 1'b0;
                busy_s   = 1'b0;
            end

            default: begin
                state_s  = ST_IDLE;
                dec_en_s = 1'b0;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            dec_in_r  <= 10'd0;
            dec_en_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
            cnt_r     <= {DWELL_W{1'b0}};
            last_r    <= 10'd0;
            dwell_r   <= {DWELL_W{1'b0}};
        end else begin
            state_r   <= state_s;
            dec_in_r  <= dec_in_s;
            dec_en_r  <= dec_en_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            aborted_r <= aborted_s;
            cnt_r     <= cnt_s;
            last_r    <= last_s;
            dwell_r   <= dwell_s;
        end
    end

    assign bus.dec_in  = dec_in_r;
    assign bus.dec_en  = dec_en_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.aborted = aborted_r;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_decoder_scan_ctrl
// Directed bench for decoder_scan_ctrl. The reference model expands an
// accepted start into the full list of expected output cycles (one entry per
// line per dwell cycle, then the done pulse); hold replays the current entry,
// abort discards the rest. Every cycle the DUT outputs are compared with the
// model, and literal expectations pin the model on the worked examples.
// -----------------------------------------------------------------------------
module tb_decoder_scan_ctrl;

    localparam int DW = 4;

    typedef struct {
        logic [9:0] a;
        logic       en;
        logic       bsy;
        logic       dn;
        logic       ab;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    decoder_scan_ctrl_if #(.DWELL_W(DW)) bus ();

    decoder_scan_ctrl #(.DWELL_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model state
    exp_t       q[$];
    logic [9:0] m_a;
    logic       m_en, m_bsy, m_dn, m_ab;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_a = 10'd0; m_en = 1'b0; m_bsy = 1'b0; m_dn = 1'b0; m_ab = 1'b0;
    endtask

    task automatic model_step(input logic s, input logic a, input logic h);
        exp_t e;
        int   fa, la, dwl, lines;
        if (m_bsy) begin
            if (a) begin
                q.delete();
                m_en = 1'b0; m_bsy = 1'b0; m_dn = 1'b0; m_ab = 1'b1;
            end else if (!h) begin
                e = q.pop_front();
                m_a = e.a; m_en = e.en; m_bsy = e.bsy; m_dn = e.dn; m_ab = e.ab;
            end
        end else if (m_dn || m_ab) begin
            m_dn = 1'b0; m_ab = 1'b0;
        end else if (s && !a) begin
            fa    = int'(bus.first_addr);
            la    = int'(bus.last_addr);
            dwl   = int'(bus.dwell);
            lines = ((la - fa + 1024) % 1024) + 1;
            q.delete();
            for (int l = 0; l < lines; l++) begin
                for (int d = 0; d <= dwl; d++) begin
                    e.a = 10'((fa + l) % 1024); e.en = 1'b1; e.bsy = 1'b1;
                    e.dn = 1'b0; e.ab = 1'b0;
                    q.push_back(e);
                end
            end
            e.a = 10'(la); e.en = 1'b0; e.bsy = 1'b0; e.dn = 1'b1; e.ab = 1'b0;
            q.push_back(e);
            e = q.pop_front();
            m_a = e.a; m_en = e.en; m_bsy = e.bsy; m_dn = e.dn; m_ab = e.ab;
        end
    endtask

    task automatic compare_model();
        chk("dec_in",  32'(bus.dec_in),  32'(m_a));
        chk("dec_en",  32'(bus.dec_en),  32'(m_en));
        chk("busy",    32'(bus.busy),    32'(m_bsy));
        chk("done",    32'(bus.done),    32'(m_dn));
        chk("aborted", 32'(bus.aborted), 32'(m_ab));
        if (bus.done && bus.aborted) chk("pulse_excl", 32'd1, 32'd0);
        if (bus.dec_en && !bus.busy) chk("en_outside_scan", 32'd1, 32'd0);
    endtask

    task automatic tick(input logic s, input logic a, input logic h);
        bus.start = s; bus.abort = a; bus.hold = h;
        @(posedge clk);
        model_step(s, a, h);
        #1;
        compare_model();
    endtask

    task automatic cfg(input int f, input int l, input int d);
        bus.first_addr = 10'(f);
        bus.last_addr  = 10'(l);
        bus.dwell      = DW'(d);
    endtask

    int en_cnt;
    int dn_cnt;
    int exp32[8];

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0;
        cfg(0, 0, 0);
        model_reset();
        #1;
        compare_model();
        chk("reset_dec_in", 32'(bus.dec_in), 32'd0);
        chk("reset_busy",   32'(bus.busy),   32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // 3..5, no dwell
        cfg(3, 5, 0);
        tick(1'b1, 1'b0, 1'b0);
        chk("t31_l0", 32'(bus.dec_in), 32'd3);
        chk("t31_en", 32'(bus.dec_en), 32'd1);
        tick(1'b0, 1'b0, 1'b0);
        chk("t31_l1", 32'(bus.dec_in), 32'd4);
        tick(1'b0, 1'b0, 1'b0);
        chk("t31_l2", 32'(bus.dec_in), 32'd5);
        tick(1'b0, 1'b0, 1'b0);
        chk("t31_done", 32'(bus.done), 32'd1);
        chk("t31_busy", 32'(bus.busy), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        chk("t31_done_off", 32'(bus.done), 32'd0);

        // wrap 1022..1, dwell 1
        cfg(1022, 1, 1);
        exp32 = '{1022, 1022, 1023, 1023, 0, 0, 1, 1};
        tick(1'b1, 1'b0, 1'b0);
        chk("t32_c0", 32'(bus.dec_in), 32'(exp32[0]));
        for (int i = 1; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk("t32_seq", 32'(bus.dec_in), 32'(exp32[i]));
        end
        tick(1'b0, 1'b0, 1'b0);
        chk("t32_done", 32'(bus.done), 32'd1);
        tick(1'b0, 1'b0, 1'b0);

        // single line with hold mid-line
        cfg(7, 7, 2);
        en_cnt = 0;
        tick(1'b1, 1'b0, 1'b0); en_cnt += int'(bus.dec_en);
        tick(1'b0, 1'b0, 1'b0); en_cnt += int'(bus.dec_en);
        tick(1'b0, 1'b0, 1'b1); en_cnt += int'(bus.dec_en);
        tick(1'b0, 1'b0, 1'b1); en_cnt += int'(bus.dec_en);
        chk("t33_hold_addr", 32'(bus.dec_in), 32'd7);
        tick(1'b0, 1'b0, 1'b0); en_cnt += int'(bus.dec_en);
        tick(1'b0, 1'b0, 1'b0); en_cnt += int'(bus.dec_en);
        chk("t33_en_cycles", 32'(en_cnt), 32'd5);
        chk("t33_done", 32'(bus.done), 32'd1);
        tick(1'b0, 1'b0, 1'b0);

        // full range, abort on the 10th scan cycle
        cfg(0, 1023, 0);
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) tick(1'b0, 1'b0, 1'b0);
        chk("t34_pre", 32'(bus.dec_in), 32'd9);
        tick(1'b0, 1'b1, 1'b1);
        chk("t34_ab",   32'(bus.aborted), 32'd1);
        chk("t34_en",   32'(bus.dec_en),  32'd0);
        chk("t34_hold", 32'(bus.dec_in),  32'd9);
        chk("t34_nodn", 32'(bus.done),    32'd0);
        tick(1'b0, 1'b0, 1'b0);
        chk("t34_ab_off", 32'(bus.aborted), 32'd0);

        // start and abort together in IDLE
        cfg(50, 60, 0);
        tick(1'b1, 1'b1, 1'b0);
        chk("t35_idle_en",   32'(bus.dec_en), 32'd0);
        chk("t35_idle_busy", 32'(bus.busy),   32'd0);
        tick(1'b0, 1'b0, 1'b0);

        // reset mid-scan
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_model();
        chk("t35_rst_dec_in", 32'(bus.dec_in), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0);
        chk("t35_post_rst_busy", 32'(bus.busy), 32'd0);

        // start during SCAN and DONE ignored, config changes ignored
        cfg(20, 22, 1);
        dn_cnt = 0;
        tick(1'b1, 1'b0, 1'b0);
        cfg(100, 200, 5);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            dn_cnt += int'(bus.done);
        end
        chk("t36_done_now", 32'(bus.done), 32'd1);
        tick(1'b1, 1'b0, 1'b0);
        dn_cnt += int'(bus.done);
        chk("t36_idle_after", 32'(bus.busy), 32'd0);
        tick(1'b0, 1'b0, 1'b0);
        dn_cnt += int'(bus.done);
        chk("t36_one_done", 32'(dn_cnt), 32'd1);
        chk("t36_last_addr", 32'(bus.dec_in), 32'd22);

        // a few mixed scans with periodic hold
        for (int k = 0; k < 3; k++) begin
            cfg(1020 + k, (2 + k * 3) % 1024, k + 1);
            tick(1'b1, 1'b0, 1'b0);
            for (int i = 0; i < 60 && (bus.busy || bus.done); i++)
                tick(1'b0, 1'b0, 1'((i % 4) == 1));
            tick(1'b0, 1'b0, 1'b0);
            chk("mix_idle", 32'(bus.busy), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
